// File: rtl/btn_pkg.sv
// Shared types and width helpers for the push-button conditioning front end.
package btn_pkg;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } btn_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Repeat spacing below 2 would make btn_pulse high on back-to-back cycles.
  function automatic int unsigned min_period(input int unsigned cycles);
    return (cycles < 2) ? 2 : cycles;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button pad and conditioned outputs bundled for the conditioner and its consumer.
interface btn_conditioner_if;

  logic btn_raw;
  logic btn_level;
  logic btn_pulse;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronise, debounce, emit one pulse per press and
// optional auto-repeat pulses while the button is held.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input logic              clk,
  input logic              rst,
  btn_conditioner_if.slave btn_io
);

  localparam int unsigned HoldTgtI = min_period(HOLD_CYCLES);
  localparam int unsigned RepTgtI  = min_period(REPEAT_CYCLES);
  localparam int unsigned CntW     = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RcntW    = cnt_width(max_u(HoldTgtI, RepTgtI));

  localparam logic [CntW-1:0]  DebMax  = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [RcntW-1:0] HoldTgt = RcntW'(HoldTgtI);
  localparam logic [RcntW-1:0] RepTgt  = RcntW'(RepTgtI);

  logic s;

  btn_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [RcntW-1:0] rcnt_q, rcnt_d;
  logic             rep_q, rep_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  logic             deb_done;
  logic             rep_fire;
  logic [CntW-1:0]  cnt_inc;
  logic [RcntW-1:0] rcnt_inc;
  logic [RcntW-1:0] rcnt_tgt;

  sync_2ff u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (btn_io.btn_raw),
    .q_o   (s)
  );

  assign deb_done = (cnt_q == DebMax);
  assign cnt_inc  = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign rcnt_inc = (rcnt_q == {RcntW{1'b1}}) ? rcnt_q : rcnt_q + 1'b1;
  // rep_q selects between the initial hold delay and the repeat period.
  assign rcnt_tgt = rep_q ? RepTgt : HoldTgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (s) state_d = StPressWait;
      end
      StPressWait: begin
        if (!s) begin
          state_d = StIdle;
        end else if (deb_done) begin
          state_d = StPressed;
        end
      end
      StPressed: begin
        if (!s) state_d = StReleaseWait;
      end
      StReleaseWait: begin
        if (s) begin
          state_d = StPressed;
        end else if (deb_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Debounce and repeat counters; a release always takes priority over a due repeat.
  always_comb begin
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    rep_d    = rep_q;
    rep_fire = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d  = s ? CntOne : '0;
        rcnt_d = '0;
        rep_d  = 1'b0;
      end
      StPressWait: begin
        if (!s || deb_done) begin
          cnt_d  = '0;
          rcnt_d = '0;
          rep_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPressed: begin
        if (!s) begin
          cnt_d  = CntOne;
          rcnt_d = '0;
          rep_d  = 1'b0;
        end else if (REPEAT_EN) begin
          if (rcnt_inc == rcnt_tgt) begin
            rep_fire = 1'b1;
            rcnt_d   = '0;
            rep_d    = 1'b1;
          end else begin
            rcnt_d = rcnt_inc;
          end
        end
      end
      StReleaseWait: begin
        rcnt_d = '0;
        rep_d  = 1'b0;
        if (s || deb_done) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d  = '0;
        rcnt_d = '0;
        rep_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    level_d = (state_d == StPressed) || (state_d == StReleaseWait);
    pulse_d = ((state_q == StPressWait) && (state_d == StPressed)) || rep_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      rcnt_q  <= '0;
      rep_q   <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      rep_q   <= rep_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_io.btn_level = level_q;
  assign btn_io.btn_pulse = pulse_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: one single-shot and one auto-repeat instance.
module tb_btn_conditioner;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Hold = 6;
  localparam int unsigned Rep  = 3;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  btn_conditioner_if if0 ();
  btn_conditioner_if if1 ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES (Deb),
    .REPEAT_EN       (1'b0),
    .HOLD_CYCLES     (Hold),
    .REPEAT_CYCLES   (Rep)
  ) dut0 (
    .clk    (clk),
    .rst    (rst),
    .btn_io (if0)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES (Deb),
    .REPEAT_EN       (1'b1),
    .HOLD_CYCLES     (Hold),
    .REPEAT_CYCLES   (Rep)
  ) dut1 (
    .clk    (clk),
    .rst    (rst),
    .btn_io (if1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    if0.btn_raw = 1'b0;
    if1.btn_raw = 1'b0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.btn_raw = 1'b0;
    if1.btn_raw = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (if0.btn_level !== 1'b0 || if0.btn_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_dut0 got level=%b pulse=%b exp 0 0", if0.btn_level, if0.btn_pulse);
    end
    total++;
    if (if1.btn_level !== 1'b0 || if1.btn_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_dut1 got level=%b pulse=%b exp 0 0", if1.btn_level, if1.btn_pulse);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (if0.btn_level !== 1'b0 || if0.btn_pulse !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got level=%b pulse=%b exp 0 0",
               if0.btn_level, if0.btn_pulse);
    end
  endtask

  task automatic test_clean_press();
    logic exp_p, exp_l;
    if0.btn_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_p = (k == 6);
      exp_l = (k >= 6);
      total++;
      if (if0.btn_pulse !== exp_p) begin
        bad++;
        $display("FAIL clean_press_pulse k=%0d got=%b exp=%b", k, if0.btn_pulse, exp_p);
      end
      total++;
      if (if0.btn_level !== exp_l) begin
        bad++;
        $display("FAIL clean_press_level k=%0d got=%b exp=%b", k, if0.btn_level, exp_l);
      end
    end
    if0.btn_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_l = (k < 6);
      total++;
      if (if0.btn_pulse !== 1'b0 || if0.btn_level !== exp_l) begin
        bad++;
        $display("FAIL clean_release k=%0d got level=%b pulse=%b exp level=%b pulse=0",
                 k, if0.btn_level, if0.btn_pulse, exp_l);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    logic exp_p, exp_l;
    pat = 5'b01101;
    for (int k = 0; k < 20; k++) begin
      if0.btn_raw = (k < 5) ? pat[k] : 1'b1;
      tick();
      exp_p = (k == 11);
      exp_l = (k >= 11);
      total++;
      if (if0.btn_pulse !== exp_p || if0.btn_level !== exp_l) begin
        bad++;
        $display("FAIL bounce k=%0d got level=%b pulse=%b exp level=%b pulse=%b",
                 k, if0.btn_level, if0.btn_pulse, exp_l, exp_p);
      end
    end
  endtask

  task automatic test_release_glitch();
    logic exp_l;
    if0.btn_raw = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (if0.btn_level !== 1'b1) begin
      bad++;
      $display("FAIL glitch_setup got level=%b exp=1", if0.btn_level);
    end
    for (int k = 0; k < 15; k++) begin
      if0.btn_raw = (k < 2) ? 1'b0 : 1'b1;
      tick();
      total++;
      if (if0.btn_pulse !== 1'b0 || if0.btn_level !== 1'b1) begin
        bad++;
        $display("FAIL release_glitch k=%0d got level=%b pulse=%b exp level=1 pulse=0",
                 k, if0.btn_level, if0.btn_pulse);
      end
    end
    if0.btn_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_l = (k < 6);
      total++;
      if (if0.btn_pulse !== 1'b0 || if0.btn_level !== exp_l) begin
        bad++;
        $display("FAIL real_release k=%0d got level=%b pulse=%b exp level=%b pulse=0",
                 k, if0.btn_level, if0.btn_pulse, exp_l);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic exp_p, exp_l;
    for (int k = 0; k < 35; k++) begin
      if1.btn_raw = (k < 23) ? 1'b1 : 1'b0;
      tick();
      exp_p = (k == 6) || (k == 12) || (k == 15) || (k == 18) || (k == 21) || (k == 24);
      exp_l = (k >= 6) && (k < 29);
      total++;
      if (if1.btn_pulse !== exp_p) begin
        bad++;
        $display("FAIL auto_repeat_pulse k=%0d got=%b exp=%b", k, if1.btn_pulse, exp_p);
      end
      total++;
      if (if1.btn_level !== exp_l) begin
        bad++;
        $display("FAIL auto_repeat_level k=%0d got=%b exp=%b", k, if1.btn_level, exp_l);
      end
    end
  endtask

  task automatic test_release_on_repeat();
    logic exp_p, exp_l;
    for (int k = 0; k < 25; k++) begin
      if1.btn_raw = (k < 13) ? 1'b1 : 1'b0;
      tick();
      exp_p = (k == 6) || (k == 12);
      exp_l = (k >= 6) && (k < 19);
      total++;
      if (if1.btn_pulse !== exp_p || if1.btn_level !== exp_l) begin
        bad++;
        $display("FAIL release_on_repeat k=%0d got level=%b pulse=%b exp level=%b pulse=%b",
                 k, if1.btn_level, if1.btn_pulse, exp_l, exp_p);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic exp_p, exp_l;
    if1.btn_raw = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    if0.btn_raw = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (if1.btn_level !== 1'b1 || if0.btn_level !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset got level0=%b level1=%b exp 0 1", if0.btn_level, if1.btn_level);
    end
    // Reset lands mid-cycle, well clear of any clock edge.
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (if0.btn_level !== 1'b0 || if0.btn_pulse !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_dut0 got level=%b pulse=%b exp 0 0",
               if0.btn_level, if0.btn_pulse);
    end
    total++;
    if (if1.btn_level !== 1'b0 || if1.btn_pulse !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_dut1 got level=%b pulse=%b exp 0 0",
               if1.btn_level, if1.btn_pulse);
    end
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_p = (k == 6);
      exp_l = (k >= 6);
      total++;
      if (if0.btn_pulse !== exp_p || if0.btn_level !== exp_l) begin
        bad++;
        $display("FAIL repress_dut0 k=%0d got level=%b pulse=%b exp level=%b pulse=%b",
                 k, if0.btn_level, if0.btn_pulse, exp_l, exp_p);
      end
      total++;
      if (if1.btn_pulse !== exp_p || if1.btn_level !== exp_l) begin
        bad++;
        $display("FAIL repress_dut1 k=%0d got level=%b pulse=%b exp level=%b pulse=%b",
                 k, if1.btn_level, if1.btn_pulse, exp_l, exp_p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    settle();
    test_bounce();
    settle();
    test_release_glitch();
    settle();
    test_auto_repeat();
    settle();
    test_release_on_repeat();
    settle();
    test_reset_mid_debounce();
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of tests");
    $fatal(1, "watchdog");
  end

endmodule
